toggle_pulse_receiver: RTL and testbench
========================================

Name: toggle_pulse_receiver

Overview:
- Receiving end of the two-phase (toggle) request/acknowledge link whose sender is a T flip-flop toggling once per event.
- Synchronises the incoming toggle, converts each level change into a one-cycle pulse, and captures the bundled data word into a one-entry buffer drained through a valid/ready interface.
- Returns a toggle acknowledge to the sender and keeps an event counter and a sticky overrun flag.

Parameters:
- WIDTH, 8: bundled data width.
- SYNC_STAGES, 2: synchroniser depth on req_tog (minimum 2).
- COUNT_W, 4: width of event_count.

Ports:
- clk  input  1  single clock, all flops rising-edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- req_tog  input  1  request toggle from the sender's T flip-flop; each level change is one event.
- data_in  input  WIDTH  bundled data; sender holds it stable from before its toggle until ack_tog changes.
- out_ready  input  1  consumer can take data_out this cycle.
- out_valid  output  1  buffer holds an unconsumed word.
- data_out  output  WIDTH  buffered word, stable while out_valid=1.
- pulse  output  1  one-cycle strobe per detected req_tog change.
- ack_tog  output  1  acknowledge toggle back to the sender.
- event_count  output  COUNT_W  detected events, modulo 2^COUNT_W.
- overrun  output  1  sticky; an event arrived while the buffer could not take it.

Behaviour:
- Reset (reset=0, asynchronous): sync chain=0, req_d=0, pulse=0, out_valid=0, data_out=0, ack_tog=0, event_count=0, overrun=0, FSM=EMPTY.
- Protocol idle level after reset is req_tog=0. Sender and receiver share reset.
- Synchroniser: req_tog shifts through SYNC_STAGES flops; last stage is req_s. req_d is req_s delayed one cycle. edge_det = req_s XOR req_d (combinational, internal).
- Latency: req_tog changes before rising edge 1.
  - edge_det is high between edges SYNC_STAGES and SYNC_STAGES+1.
  - pulse is high for exactly one cycle after edge SYNC_STAGES+1; with the default, pulse rises at the 3rd edge.
  - Capture, out_valid rise and event_count increment occur at that same edge.
- event_count increments on every edge_det, including dropped events, and wraps from 2^COUNT_W-1 to 0.
- FSM EMPTY:
  - edge_det: data_out<=data_in, out_valid<=1, go FULL.
  - Otherwise hold.
- FSM FULL:
  - out_ready=1 and no edge_det: out_valid<=0, ack_tog<=~ack_tog, go EMPTY.
  - out_ready=1 and edge_det in the same cycle: old word consumed, ack_tog toggles, data_out<=data_in, out_valid stays 1, stay FULL.
  - out_ready=0 and edge_det: new word dropped, data_out unchanged, overrun<=1, stay FULL, no ack toggle.
  - out_ready=0, no edge_det: hold.
- ack_tog toggles only on consumption (out_valid & out_ready at a rising edge). It never toggles on capture or drop.
- overrun clears only by reset.
- data_out is registered and changes only on capture or reset.
- Reset mid-operation clears everything asynchronously; any buffered word is lost. No pulse and no event occur at reset release while req_tog=0.
- The out_ready=1 / out_valid=0 combination has no effect.

Test Plan:
Defaults: WIDTH=8, SYNC_STAGES=2, COUNT_W=4.
1. Hold reset=0 with req_tog=0 and data_in=8'hFF, then release.
   - Required: all outputs 0 throughout.
   - Required: no pulse over 10 cycles after release.
2. data_in=8'hA5, req_tog 0->1, out_ready=0.
   - Required at 3rd edge: pulse=1 for one cycle, out_valid=1, data_out=8'hA5, event_count=1, ack_tog=0.
   - Then raise out_ready=1. Required next edge: out_valid=0, ack_tog=1.
3. After case 2: data_in=8'h3C, req_tog 1->0, out_ready held 1.
   - Required: data_out=8'h3C, out_valid high for one cycle, then ack_tog=0, event_count=2, overrun=0.
4. Two toggles (data 8'h11 then 8'h22) with out_ready=0 throughout.
   - Required: data_out=8'h11, overrun=1, event_count=2, ack_tog unchanged.
   - Required: overrun stays 1 after draining.
5. Time a toggle (data 8'h55) so edge_det coincides with out_ready=1 while holding 8'h44.
   - Required: ack_tog toggles, data_out=8'h55, out_valid stays 1, overrun=0.
6. Seventeen events, consuming each.
   - Required: event_count reaches 15, then 0, then 1.
   - Assert reset=0 while out_valid=1. Required: all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/toggle_pulse_receiver.sv
`default_nettype none
// ============================================================================
// Module   : toggle_pulse_receiver
// Brief    : Two-phase (toggle) link receiver with one-word valid/ready buffer,
//            toggle acknowledge, event counter and sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_pulse_receiver #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_tog,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   data_out,
    output logic               pulse,
    output logic               ack_tog,
    output logic [COUNT_W-1:0] event_count,
    output logic               overrun
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                   r_state;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_req_d;
    logic                     r_pulse;
    logic                     r_valid;
    logic [WIDTH-1:0]         r_data;
    logic                     r_ack;
    logic [COUNT_W-1:0]       r_count;
    logic                     r_overrun;
    logic                     w_req_s;
    logic                     w_edge;

    assign w_req_s = r_sync[SYNC_STAGES-1];
    assign w_edge  = w_req_s ^ r_req_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= '0;
            r_req_d   <= 1'b0;
            r_pulse   <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_ack     <= 1'b0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_state   <= EMPTY;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], req_tog};
            r_req_d <= w_req_s;
            r_pulse <= w_edge;
            // Counts every detected event, dropped ones included.
            if (w_edge) begin
                r_count <= r_count + 1'b1;
            end
            case (r_state)
                EMPTY: begin
                    if (w_edge) begin
                        r_data  <= data_in;
                        r_valid <= 1'b1;
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        // Consumption acknowledges; a coinciding event refills.
                        r_ack <= ~r_ack;
                        if (w_edge) begin
                            r_data <= data_in;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= EMPTY;
                        end
                    end else if (w_edge) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    assign out_valid   = r_valid;
    assign data_out    = r_data;
    assign pulse       = r_pulse;
    assign ack_tog     = r_ack;
    assign event_count = r_count;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_toggle_pulse_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_pulse_receiver
// Brief    : Directed self-checking bench for toggle_pulse_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_pulse_receiver;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int COUNT_W     = 4;

    logic               clk;
    logic               reset;
    logic               req_tog;
    logic [WIDTH-1:0]   data_in;
    logic               out_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   data_out;
    logic               pulse;
    logic               ack_tog;
    logic [COUNT_W-1:0] event_count;
    logic               overrun;

    int n_cmp;
    int n_err;

    toggle_pulse_receiver #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .COUNT_W     (COUNT_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_tog     (req_tog),
        .data_in     (data_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .data_out    (data_out),
        .pulse       (pulse),
        .ack_tog     (ack_tog),
        .event_count (event_count),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of all outputs: {out_valid, data_out, pulse, ack_tog, event_count, overrun}
    function automatic logic [WIDTH+COUNT_W+3:0] outs();
        return {out_valid, data_out, pulse, ack_tog, event_count, overrun};
    endfunction

    task automatic do_reset();
        reset     = 1'b0;
        req_tog   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_tog   = 1'b0;
        data_in   = 8'hFF;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", outs());
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs() !== '0) begin
                n_err++;
                $display("FAIL post_reset_idle cycle %0d: got %h want 0", i, outs());
            end
        end
    endtask

    task automatic test_single_event();
        data_in   = 8'hA5;
        req_tog   = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pulse !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL early_pulse: pulse=%b valid=%b want 0 0", pulse, out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (pulse !== 1'b1 || out_valid !== 1'b1 || data_out !== 8'hA5 ||
            event_count !== 4'd1 || ack_tog !== 1'b0) begin
            n_err++;
            $display("FAIL capture_A5: pulse=%b valid=%b data=%h cnt=%0d ack=%b want 1 1 a5 1 0",
                     pulse, out_valid, data_out, event_count, ack_tog);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pulse !== 1'b0 || out_valid !== 1'b0 || ack_tog !== 1'b1 || data_out !== 8'hA5) begin
            n_err++;
            $display("FAIL consume_A5: pulse=%b valid=%b ack=%b data=%h want 0 0 1 a5",
                     pulse, out_valid, ack_tog, data_out);
        end
    endtask

    task automatic test_ready_held();
        data_in = 8'h3C;
        req_tog = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pulse !== 1'b1 || out_valid !== 1'b1 || data_out !== 8'h3C || event_count !== 4'd2) begin
            n_err++;
            $display("FAIL capture_3C: pulse=%b valid=%b data=%h cnt=%0d want 1 1 3c 2",
                     pulse, out_valid, data_out, event_count);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || ack_tog !== 1'b0 || event_count !== 4'd2 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL consume_3C: valid=%b ack=%b cnt=%0d ovr=%b want 0 0 2 0",
                     out_valid, ack_tog, event_count, overrun);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        data_in = 8'h11;
        req_tog = 1'b1;
        repeat (3) @(negedge clk);
        data_in = 8'h22;
        req_tog = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (data_out !== 8'h11 || overrun !== 1'b1 || event_count !== 4'd2 ||
            ack_tog !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_drop: data=%h ovr=%b cnt=%0d ack=%b valid=%b want 11 1 2 0 1",
                     data_out, overrun, event_count, ack_tog, out_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || ack_tog !== 1'b1 || overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky: valid=%b ack=%b ovr=%b want 0 1 1",
                     out_valid, ack_tog, overrun);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        data_in = 8'h44;
        req_tog = 1'b1;
        repeat (3) @(negedge clk);
        data_in = 8'h55;
        req_tog = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || data_out !== 8'h44 || ack_tog !== 1'b0) begin
            n_err++;
            $display("FAIL hold_44: valid=%b data=%h ack=%b want 1 44 0", out_valid, data_out, ack_tog);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ack_tog !== 1'b1 || data_out !== 8'h55 || out_valid !== 1'b1 ||
            overrun !== 1'b0 || pulse !== 1'b1 || event_count !== 4'd2) begin
            n_err++;
            $display("FAIL swap_55: ack=%b data=%h valid=%b ovr=%b pulse=%b cnt=%0d want 1 55 1 0 1 2",
                     ack_tog, data_out, out_valid, overrun, pulse, event_count);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || ack_tog !== 1'b0 || data_out !== 8'h55) begin
            n_err++;
            $display("FAIL drain_55: valid=%b ack=%b data=%h want 0 0 55", out_valid, ack_tog, data_out);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_count_wrap_and_async_reset();
        logic [COUNT_W-1:0] exp_cnt;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            data_in = 8'(i);
            req_tog = ~req_tog;
            repeat (3) @(negedge clk);
            exp_cnt = COUNT_W'(i + 1);
            n_cmp++;
            if (event_count !== exp_cnt || data_out !== 8'(i) || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL count_event %0d: cnt=%0d data=%h valid=%b want %0d %h 1",
                         i, event_count, data_out, out_valid, exp_cnt, 8'(i));
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        data_in   = 8'hC3;
        req_tog   = ~req_tog;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || data_out !== 8'hC3 || event_count !== 4'd2) begin
            n_err++;
            $display("FAIL pre_async_reset: valid=%b data=%h cnt=%0d want 1 c3 2",
                     out_valid, data_out, event_count);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL async_reset: got %h want 0", outs());
        end
        req_tog = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL release_quiet: got %h want 0", outs());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_event();
        test_ready_held();
        test_overrun();
        test_back_to_back();
        test_count_wrap_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
